// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDRESS_WIDTH = 3,
    parameter int ALMOST_FULL   = 6,
    parameter int ALMOST_EMPTY  = 1,
    parameter bit FWFT          = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     clear_errors,
    input  logic                     write_increment,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     read_increment,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     read_valid,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int CNT_W = ADDRESS_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(ALMOST_FULL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(ALMOST_EMPTY);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic [ADDRESS_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]         count_reg, count_next;
    logic                     overflow_reg, overflow_next;
    logic                     underflow_reg, underflow_next;

    logic full_flag;
    logic empty_flag;
    logic push_accept;
    logic pop_accept;

    // Flags decode the registered count, so they follow an update by one cycle.
    assign full_flag  = (count_reg == DEPTH_CNT);
    assign empty_flag = (count_reg == '0);

    assign push_accept = write_increment && !full_flag  && !flush;
    assign pop_accept  = read_increment  && !empty_flag && !flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (clear_errors) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // A dropped request sets its flag even when clear_errors is high.
            if (write_increment && full_flag) begin
                overflow_next = 1'b1;
            end
            if (read_increment && empty_flag) begin
                underflow_next = 1'b1;
            end
            if (push_accept) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop_accept) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push_accept, pop_accept})
                2'b10:   count_next = count_reg + ONE_CNT;
                2'b01:   count_next = count_reg - ONE_CNT;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage carries no reset so it can map onto block or distributed RAM.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr_reg] <= write_data;
        end
    end

    generate
        if (FWFT == 1'b0) begin : g_registered_read
            logic [DATA_WIDTH-1:0] read_data_reg;
            logic                  read_valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    read_data_reg  <= '0;
                    read_valid_reg <= 1'b0;
                end else begin
                    read_valid_reg <= pop_accept;
                    if (pop_accept) begin
                        read_data_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign read_data  = read_data_reg;
            assign read_valid = read_valid_reg;
        end else begin : g_fwft_read
            // The head entry is presented directly; zero while nothing is stored.
            assign read_data  = empty_flag ? '0 : mem[rd_ptr_reg];
            assign read_valid = !empty_flag;
        end
    endgenerate

    assign count        = count_reg;
    assign full         = full_flag;
    assign empty        = empty_flag;
    assign almost_full  = (count_reg >= AF_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives one registered-read and one FWFT instance with identical stimulus and
// checks both every cycle against a queue model, plus literal spot checks.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, clear_errors, write_increment, read_increment;
    logic [3:0] write_data;

    logic [3:0] rd0, rd1;
    logic       rv0, rv1;
    logic [3:0] cnt0, cnt1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: queue contents, sticky errors, registered-read outputs.
    logic [3:0] q[$];
    logic       m_ovf, m_unf, m_rv0;
    logic [3:0] m_rd0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_WIDTH(4), .ADDRESS_WIDTH(3), .ALMOST_FULL(6),
                      .ALMOST_EMPTY(1), .FWFT(1'b0)) dut_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clear_errors(clear_errors),
        .write_increment(write_increment), .write_data(write_data),
        .read_increment(read_increment), .read_data(rd0), .read_valid(rv0),
        .count(cnt0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .overflow(ovf0), .underflow(unf0));

    sync_fifo_flags #(.DATA_WIDTH(4), .ADDRESS_WIDTH(3), .ALMOST_FULL(6),
                      .ALMOST_EMPTY(1), .FWFT(1'b1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clear_errors(clear_errors),
        .write_increment(write_increment), .write_data(write_data),
        .read_increment(read_increment), .read_data(rd1), .read_valid(rv1),
        .count(cnt1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .overflow(ovf1), .underflow(unf1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv0 = 1'b0;
        m_rd0 = 4'h0;
    endtask

    task automatic model_update(input bit wi, input logic [3:0] wd, input bit ri,
                                input bit fl, input bit ce);
        bit was_full, was_empty, set_o, set_u;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        set_o = wi && was_full && !fl;
        set_u = ri && was_empty && !fl;
        m_ovf = set_o || (m_ovf && !ce);
        m_unf = set_u || (m_unf && !ce);
        m_rv0 = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (ri && !was_empty) begin
                m_rd0 = q.pop_front();
                m_rv0 = 1'b1;
            end
            if (wi && !was_full) q.push_back(wd);
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the active edge.
    task automatic step(input bit wi, input logic [3:0] wd, input bit ri,
                        input bit fl, input bit ce);
        write_increment = wi;
        write_data      = wd;
        read_increment  = ri;
        flush           = fl;
        clear_errors    = ce;
        @(posedge clk);
        model_update(wi, wd, ri, fl, ce);
        #1;
        write_increment = 1'b0;
        read_increment  = 1'b0;
        flush           = 1'b0;
        clear_errors    = 1'b0;
        write_data      = 4'h0;
        $display("t=%0t wi=%0d wd=%h ri=%0d fl=%0d ce=%0d -> count=%0d rd0=%h rv0=%0d rd1=%h rv1=%0d",
                 $time, wi, wd, ri, fl, ce, cnt0, rd0, rv0, rd1, rv1);
    endtask

    // Per-cycle comparison against the model on the inactive edge.
    always @(negedge clk) begin
        int sz;
        sz = q.size();
        chk("count_reg_mode",  32'(cnt0),   32'(sz));
        chk("count_fwft_mode", 32'(cnt1),   32'(sz));
        chk("full",            32'(full0),  32'(sz == 8));
        chk("empty",           32'(empty0), 32'(sz == 0));
        chk("almost_full",     32'(af0),    32'(sz >= 6));
        chk("almost_empty",    32'(ae0),    32'(sz <= 1));
        chk("overflow",        32'(ovf0),   32'(m_ovf));
        chk("underflow",       32'(unf0),   32'(m_unf));
        chk("flags_fwft",      32'({full1, empty1, af1, ae1, ovf1, unf1}),
                               32'({full0, empty0, af0, ae0, ovf0, unf0}) & 32'h0
                               | 32'({sz == 8, sz == 0, sz >= 6, sz <= 1, m_ovf, m_unf}));
        chk("read_valid_reg",  32'(rv0),    32'(m_rv0));
        chk("read_data_reg",   32'(rd0),    32'(m_rd0));
        chk("read_valid_fwft", 32'(rv1),    32'(sz != 0));
        chk("read_data_fwft",  32'(rd1),    (sz != 0) ? 32'(q[0]) : 32'h0);
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        clear_errors = 1'b0;
        write_increment = 1'b0;
        read_increment = 1'b0;
        write_data = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset_count", 32'(cnt0), 0);
        chk("reset_empty", 32'(empty0), 1);
        chk("reset_almost_empty", 32'(ae0), 1);
        chk("reset_read_data_fwft", 32'(rd1), 0);

        // Fill with 1..8 and watch the threshold flags move.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
            chk("t1_count", 32'(cnt0), 32'(i));
            chk("t1_almost_empty", 32'(ae0), 32'(i <= 1));
            chk("t1_almost_full", 32'(af0), 32'(i >= 6));
        end
        chk("t1_full", 32'(full0), 1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            chk("t1_pop_data", 32'(rd0), 32'(i));
            chk("t1_pop_valid", 32'(rv0), 1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid_drops", 32'(rv0), 0);

        // Full FIFO with simultaneous push and pop: push is dropped.
        for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
        chk("t2_head", 32'(rd0), 1);
        chk("t2_count", 32'(cnt0), 7);
        chk("t2_overflow", 32'(ovf0), 1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("t2_cleared", 32'(ovf0), 0);
        for (int i = 2; i <= 8; i++) begin
            step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            chk("t2_drain", 32'(rd0), 32'(i));
        end

        // Empty FIFO with simultaneous push and pop: pop is dropped.
        step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        chk("t3_count", 32'(cnt0), 1);
        chk("t3_underflow", 32'(unf0), 1);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t3_pop", 32'(rd0), 5);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Interleaved traffic around three entries, crossing the pointer wrap.
        for (int i = 1; i <= 3; i++) step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            case (k % 4)
                0, 2:    step(1'b1, 4'(k + 4), 1'b1, 1'b0, 1'b0);
                1:       step(1'b1, 4'(k + 4), 1'b0, 1'b0, 1'b0);
                default: step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            endcase
            chk("t4_count_range", 32'(cnt0 >= 2 && cnt0 <= 4), 1);
        end
        while (q.size() != 0) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t4_drained", 32'(empty0), 1);

        // Fall-through presentation without a pop.
        step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        chk("t5_fwft_data", 32'(rd1), 3);
        chk("t5_fwft_valid", 32'(rv1), 1);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_fwft_empty", 32'(empty1), 1);
        chk("t5_fwft_zero", 32'(rd1), 0);

        // Flush with a concurrent push.
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i + 8), 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
        chk("t6_flush_count", 32'(cnt0), 0);
        chk("t6_flush_empty", 32'(empty0), 1);
        chk("t6_flush_errors", 32'({ovf0, unf0}), 0);

        // Asynchronous reset mid-stream.
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_count", 32'(cnt0), 0);
        chk("t6_rst_empty", 32'(empty0), 1);
        chk("t6_rst_valid", 32'({rv0, rv1}), 0);
        chk("t6_rst_data_reg", 32'(rd0), 0);
        chk("t6_rst_data_fwft", 32'(rd1), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("t6_after_rst_fwft", 32'(rd1), 9);
        chk("t6_after_rst_count", 32'(cnt0), 1);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t6_after_rst_pop", 32'(rd0), 9);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
